fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Fetch stage plus F/D pipeline register for the 5-stage RV32I core. Owns the PC register, drives the instruction memory address and latches the fetched instruction into D. Consumes `stall` (load-use hold) and `pc_sel` with its target (X-stage branch/jump redirect) from the X-stage control/forwarding unit. Produces the D-stage instruction/PC and the flush request for the D/X register.

Parameters:
- RESET_PC, 32'h0100_0000, PC loaded on reset.
- NOP_INSN, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).
- XLEN, 32, address/data width.

Ports:
- clock  in  1  core clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  load-use stall from the X control unit; hold F and D.
- pc_sel  in  1  redirect taken in X (branch taken, JAL, JALR).
- br_target  in  XLEN  redirect target (X ALU result).
- imem_addr  out  XLEN  instruction memory address, combinational read.
- imem_data  in  32  instruction word at imem_addr, same cycle.
- f_pc  out  XLEN  current fetch PC.
- d_pc  out  XLEN  PC of the instruction in D.
- d_insn  out  32  instruction in D.
- d_valid  out  1  D holds a real (non-bubble) instruction.
- x_flush  out  1  load NOP into D/X next edge.
- x_bubble  out  1  insert NOP into D/X next edge, D/X upstream hold.

Behaviour:
- FSM states: BOOT and RUN. Reset enters BOOT. BOOT lasts exactly one cycle, then moves to RUN. No other transitions except reset.
- Reset values: f_pc=RESET_PC, d_pc=RESET_PC, d_insn=NOP_INSN, d_valid=0, state=BOOT. Counters (if present) are 0.
- imem_addr = f_pc (combinational). Zero-latency memory is assumed; imem_data is sampled on the same edge.
- BOOT: f_pc holds RESET_PC. D stays NOP with d_valid=0. `stall` and `pc_sel` are ignored.
- RUN priority per edge: reset > pc_sel > stall > normal advance.
  - pc_sel=1: f_pc <= {br_target[XLEN-1:1],1'b0}; d_insn <= NOP_INSN; d_valid <= 0; d_pc <= br_target-aligned value. `stall` is ignored in the same cycle.
  - stall=1 (pc_sel=0): f_pc, d_pc, d_insn and d_valid all hold.
  - Normal: d_insn <= imem_data; d_pc <= f_pc; d_valid <= 1; f_pc <= f_pc + 4.
- x_flush = pc_sel & (state==RUN), combinational. The D/X register loads a NOP so the wrong-path instruction already in D is killed. Two wrong-path slots are squashed in total: one in D via d_insn, one entering X via x_flush.
- x_bubble = stall & ~pc_sel & (state==RUN), combinational.
- PC arithmetic is modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset asserted mid-stall or mid-redirect wins unconditionally and returns to BOOT.
- A held stall of any length produces no PC drift and no duplicate instruction.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined: adds outputs perf_cycles, perf_stalls and perf_flushes, each 32 bits.
  - perf_cycles increments every RUN cycle.
  - perf_stalls increments when x_bubble=1.
  - perf_flushes increments when x_flush=1.
  - All counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and their logic are absent. Datapath behaviour is identical.

Test Plan:
- Reset release, imem returning addr-derived words, no stall/pc_sel:
  - Cycle 1 (BOOT): f_pc=0x0100_0000, d_valid=0.
  - Following cycles: d_pc goes 0x0100_0000, 0x0100_0004, ... with d_valid=1.
- Stall held 3 cycles at f_pc=0x0100_0008:
  - f_pc, d_pc and d_insn hold for the full 3 cycles; x_bubble=1 for 3 cycles.
  - Resumes with d_pc=0x0100_0008 next, no skip and no duplicate.
- pc_sel=1 with br_target=0x0100_0101:
  - x_flush=1 that cycle.
  - Next edge: f_pc=0x0100_0100, d_insn=0x0000_0013, d_valid=0.
  - Following edge: d_pc=0x0100_0100.
- stall=1 and pc_sel=1 together with target 0x0100_0040:
  - Redirect wins: f_pc=0x0100_0040, x_bubble=0, x_flush=1.
- f_pc=0xFFFF_FFFC, normal advance -> f_pc=0x0000_0000, d_pc=0xFFFF_FFFC.
- Reset asserted during an active stall with f_pc=0x0100_0020 -> next edge f_pc=0x0100_0000, d_valid=0, BOOT state. With FETCH_PERF_COUNTERS_EN defined, all counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage plus F/D pipeline register for the 5-stage RV32I core.
//
// Owns the fetch PC and presents it as the address of a zero-latency instruction
// memory. The returned word is latched into the D stage on the next rising edge.
// The X-stage control unit can hold the stage (stall) or redirect it (pc_sel).
//
// Ports:
//   clock      - core clock; all state updates on the rising edge
//   reset      - synchronous, active-high
//   stall      - load-use hold from X; F and D keep their contents
//   pc_sel     - redirect taken in X (taken branch, JAL, JALR)
//   br_target  - redirect target; bit 0 is cleared before use
//   imem_addr  - instruction memory address (equal to f_pc)
//   imem_data  - instruction word at imem_addr, valid in the same cycle
//   f_pc       - current fetch PC
//   d_pc       - PC of the instruction held in D
//   d_insn     - instruction held in D
//   d_valid    - D holds a real instruction, not a bubble
//   x_flush    - D/X register loads a NOP on the next edge
//   x_bubble   - D/X register inserts a NOP on the next edge; upstream holds
//   perf_*     - cycle/stall/flush counters, present only with
//                FETCH_PERF_COUNTERS_EN defined
//
// Optional feature macro: FETCH_PERF_COUNTERS_EN

module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [XLEN-1:0] f_pc,
  output logic [XLEN-1:0] d_pc,
  output logic [31:0]     d_insn,
  output logic            d_valid,
  output logic            x_flush,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic            x_bubble,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stalls,
  output logic [31:0]     perf_flushes
`else
  output logic            x_bubble
`endif
);

  typedef enum logic {StBoot, StRun} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] f_pc_q, f_pc_d;
  logic [XLEN-1:0] d_pc_q, d_pc_d;
  logic [31:0]     d_insn_q, d_insn_d;
  logic            d_valid_q, d_valid_d;
  logic [XLEN-1:0] redirect_pc;
  logic            run;

  assign run         = (state_q == StRun);
  // Instructions are at least halfword aligned; drop bit 0 of the JALR-style target.
  assign redirect_pc = br_target & ~XLEN'(1);

  assign imem_addr = f_pc_q;
  assign f_pc      = f_pc_q;
  assign d_pc      = d_pc_q;
  assign d_insn    = d_insn_q;
  assign d_valid   = d_valid_q;
  // Kills the wrong-path instruction currently in D as it moves into X.
  assign x_flush   = pc_sel & run;
  assign x_bubble  = stall & ~pc_sel & run;

  always_comb begin
    state_d   = StRun;
    f_pc_d    = f_pc_q;
    d_pc_d    = d_pc_q;
    d_insn_d  = d_insn_q;
    d_valid_d = d_valid_q;
    if (run) begin
      if (pc_sel) begin
        // Redirect beats stall: the stalled instruction is on the wrong path anyway.
        f_pc_d    = redirect_pc;
        d_pc_d    = redirect_pc;
        d_insn_d  = NOP_INSN;
        d_valid_d = 1'b0;
      end else if (!stall) begin
        f_pc_d    = f_pc_q + XLEN'(4);
        d_pc_d    = f_pc_q;
        d_insn_d  = imem_data;
        d_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StBoot;
      f_pc_q    <= RESET_PC;
      d_pc_q    <= RESET_PC;
      d_insn_q  <= NOP_INSN;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_pc_q    <= f_pc_d;
      d_pc_q    <= d_pc_d;
      d_insn_q  <= d_insn_d;
      d_valid_q <= d_valid_d;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] cycles_q, stalls_q, flushes_q;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_q  <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      cycles_q  <= sat_inc(cycles_q, run);
      stalls_q  <= sat_inc(stalls_q, x_bubble);
      flushes_q <= sat_inc(flushes_q, x_flush);
    end
  end

  assign perf_cycles  = cycles_q;
  assign perf_stalls  = stalls_q;
  assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps from the test plan followed by random
// stall/redirect/reset traffic, all compared against a cycle-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0100_0000;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] imem_addr, imem_data, f_pc, d_pc, d_insn;
  logic        d_valid, x_flush, x_bubble;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_cycles, perf_stalls, perf_flushes;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the fetch stage should hold after each edge.
  logic [31:0] m_fpc, m_dpc, m_dinsn;
  logic        m_dv;
  logic        m_running;
  logic [31:0] m_cyc, m_stl, m_fls;

  fetch_stage dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .pc_sel    (pc_sel),
    .br_target (br_target),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .f_pc      (f_pc),
    .d_pc      (d_pc),
    .d_insn    (d_insn),
    .d_valid   (d_valid),
    .x_flush   (x_flush),
`ifdef FETCH_PERF_COUNTERS_EN
    .x_bubble     (x_bubble),
    .perf_cycles  (perf_cycles),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
`else
    .x_bubble  (x_bubble)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory contents: an address-derived hash so every word differs.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_data = imem_word(imem_addr);

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("f_pc", f_pc, m_fpc);
    chk("d_pc", d_pc, m_dpc);
    chk("d_insn", d_insn, m_dinsn);
    chk("d_valid", 32'(d_valid), 32'(m_dv));
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_cycles", perf_cycles, m_cyc);
    chk("perf_stalls", perf_stalls, m_stl);
    chk("perf_flushes", perf_flushes, m_fls);
`endif
  endtask

  // One cycle: apply inputs, check combinational outputs, clock, advance model, check state.
  task automatic step(input logic rst, input logic st, input logic ps, input logic [31:0] tgt);
    logic exp_flush, exp_bubble;
    reset = rst; stall = st; pc_sel = ps; br_target = tgt;
    #1;
    exp_flush  = ps & m_running;
    exp_bubble = st & ~ps & m_running;
    chk("imem_addr", imem_addr, m_fpc);
    chk("x_flush", 32'(x_flush), 32'(exp_flush));
    chk("x_bubble", 32'(x_bubble), 32'(exp_bubble));
    @(posedge clock);
    if (rst) begin
      m_fpc = RstPc; m_dpc = RstPc; m_dinsn = Nop; m_dv = 1'b0; m_running = 1'b0;
      m_cyc = 0; m_stl = 0; m_fls = 0;
    end else if (!m_running) begin
      m_running = 1'b1;  // the boot cycle ignores stall and redirect
    end else begin
      m_cyc = sat1(m_cyc);
      if (exp_bubble) m_stl = sat1(m_stl);
      if (exp_flush)  m_fls = sat1(m_fls);
      if (ps) begin
        m_fpc = tgt - (tgt % 2);
        m_dpc = m_fpc; m_dinsn = Nop; m_dv = 1'b0;
      end else if (!st) begin
        m_dinsn = imem_word(m_fpc);
        m_dpc = m_fpc; m_dv = 1'b1;
        m_fpc = m_fpc + 4;
      end
    end
    #1;
    chk_regs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_fpc = 'x; m_dpc = 'x; m_dinsn = 'x; m_dv = 1'b0; m_running = 1'b0;
    m_cyc = 0; m_stl = 0; m_fls = 0;

    // Reset, then the boot cycle.
    step(1, 0, 0, 0);
    chk("reset f_pc", f_pc, 32'h0100_0000);
    chk("reset d_valid", 32'(d_valid), 0);
    step(0, 0, 0, 0);
    chk("boot f_pc", f_pc, 32'h0100_0000);
    chk("boot d_valid", 32'(d_valid), 0);

    // Normal advance.
    step(0, 0, 0, 0);
    chk("run1 d_pc", d_pc, 32'h0100_0000);
    chk("run1 d_valid", 32'(d_valid), 1);
    step(0, 0, 0, 0);
    chk("run2 d_pc", d_pc, 32'h0100_0004);
    chk("run2 f_pc", f_pc, 32'h0100_0008);

    // Three-cycle stall at f_pc = 0x0100_0008.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall f_pc", f_pc, 32'h0100_0008);
      chk("stall d_pc", d_pc, 32'h0100_0004);
    end
    step(0, 0, 0, 0);
    chk("resume d_pc", d_pc, 32'h0100_0008);
    chk("resume d_insn", d_insn, imem_word(32'h0100_0008));

    // Redirect to a misaligned target.
    step(0, 0, 1, 32'h0100_0101);
    chk("redir f_pc", f_pc, 32'h0100_0100);
    chk("redir d_insn", d_insn, 32'h0000_0013);
    chk("redir d_valid", 32'(d_valid), 0);
    step(0, 0, 0, 0);
    chk("after redir d_pc", d_pc, 32'h0100_0100);

    // Redirect and stall together: redirect wins.
    stall = 1; pc_sel = 1; #1;
    chk("both x_bubble", 32'(x_bubble), 0);
    chk("both x_flush", 32'(x_flush), 1);
    step(0, 1, 1, 32'h0100_0040);
    chk("both f_pc", f_pc, 32'h0100_0040);

    // PC wrap.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap f_pc", f_pc, 32'h0000_0000);
    chk("wrap d_pc", d_pc, 32'hFFFF_FFFC);

    // Reset during a stall.
    step(0, 0, 1, 32'h0100_0020);
    step(0, 1, 0, 0);
    chk("pre-reset f_pc", f_pc, 32'h0100_0020);
    step(1, 1, 0, 0);
    chk("mid-stall reset f_pc", f_pc, 32'h0100_0000);
    chk("mid-stall reset d_valid", 32'(d_valid), 0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("reset perf_cycles", perf_cycles, 0);
    chk("reset perf_stalls", perf_stalls, 0);
    chk("reset perf_flushes", perf_flushes, 0);
`endif
    // Still in boot: a redirect here must be ignored.
    pc_sel = 1; reset = 0; #1;
    chk("boot x_flush", 32'(x_flush), 0);
    step(0, 0, 1, 32'h0200_0000);
    chk("boot ignores redir", f_pc, 32'h0100_0000);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_st, r_ps;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(99) < 2);
      r_st  = ($urandom_range(3) == 0);
      r_ps  = ($urandom_range(6) == 0);
      r_tgt = ($urandom_range(1) == 1) ? $urandom : 32'h0100_0000 + $urandom_range(255);
      step(r_rst, r_st, r_ps, r_tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
